cpu_test_sequencer: RTL and testbench
=====================================

CPU_TEST_SEQUENCER -- requirements
Module: cpu_test_sequencer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NUM_TESTS, 3, number of entries in the vector table.
- RST_CYCLES, 2, cycles cpu_reset is held per test.
- TIMEOUT, 16'd4000, maximum RUN cycles per test.
REQ-002 Vector table SHALL be internal constants {stimulus, expected}: test 0 = {16'h13B0, 16'h000B}, test 1 = {16'h0906, 16'd13}, test 2 = {16'h754E, 16'd17}.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, single system clock, rising edge.
- reset, input, 1, asynchronous, active-low block reset.
- start, input, 1, begin a test pass; sampled in IDLE or DONE only.
- cpu_out, input, 16, CPU output port under test.
- cpu_in, output, 16, stimulus to the CPU input port.
- cpu_reset, output, 1, active-high reset to the CPU.
- busy, output, 1, high in RESET, RUN and NEXT.
- done, output, 1, high in DONE.
- test_idx, output, 4, index of the current test.
- pass_count, output, 4, tests that matched.
- fail_count, output, 4, tests that timed out.
- cycle_total, output, 32, cumulative cycles in the RESET and RUN states.
- last_cycles, output, 16, RUN cycles of the most recently finished test.
REQ-004 All outputs SHALL be registered.

Function
REQ-005 The FSM states SHALL be IDLE, RESET, RUN, NEXT and DONE.
REQ-006 IDLE: cpu_reset=1, cpu_in=0; start=1 -> RESET with test_idx=0 and pass_count, fail_count, cycle_total and last_cycles all cleared.
REQ-007 RESET: cpu_reset=1 and cpu_in=stimulus[test_idx] for exactly RST_CYCLES cycles, then -> RUN; cycle_total increments each cycle.
REQ-008 RUN: cpu_reset=0 and cpu_in is held stable; a per-test counter starts at 1 in the first RUN cycle; cycle_total increments each RUN cycle.
REQ-009 RUN, match: cpu_out==expected[test_idx] is sampled at a clock edge -> pass_count+1, last_cycles=counter, -> NEXT.
REQ-010 RUN, timeout: no match and counter==TIMEOUT -> fail_count+1, last_cycles=TIMEOUT, -> NEXT.
REQ-011 Match and timeout in the same cycle SHALL count as a pass.
REQ-012 A match SHALL only be recognised in RUN; cpu_out is ignored in IDLE, RESET, NEXT and DONE.
REQ-013 NEXT (1 cycle): cpu_reset=1; if test_idx==NUM_TESTS-1 -> DONE, else test_idx+1 and -> RESET.
REQ-014 DONE: cpu_reset=1; counters hold; done stays high until start=1, which behaves as in REQ-006.
REQ-015 start SHALL be ignored while busy=1.
REQ-016 cycle_total SHALL wrap modulo 2^32.
REQ-017 pass_count+fail_count SHALL equal NUM_TESTS on entry to DONE.

Reset
REQ-018 reset=0 SHALL asynchronously force state=IDLE, cpu_reset=1, cpu_in=0, busy=0, done=0, and test_idx=pass_count=fail_count=cycle_total=last_cycles=0.
REQ-019 A reset asserted mid-test SHALL abandon the pass without updating any counter.
REQ-020 After reset deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-021 CPU model raising cpu_out to the expected value K cycles into RUN for every test (K=5, 7, 9), start pulsed -> pass_count=3, fail_count=0, last_cycles=9, cycle_total=3*RST_CYCLES+21=27, done=1.
REQ-022 Test 1 never matches, TIMEOUT=10 -> fail_count=1, pass_count=2, test 2 still runs, last_cycles for test 1 =10.
REQ-023 cpu_out already equals 16'h000B during RESET -> no pass until RUN; with cpu_out held, a pass at counter=1.
REQ-024 start pulsed in RUN -> ignored; start pulsed in DONE -> counters clear and test 0 restarts with cpu_in=16'h13B0.
REQ-025 reset=0 in RUN of test 1 -> immediate IDLE, cpu_reset=1, all counters 0, done=0.
REQ-026 Match in the exact cycle counter==TIMEOUT -> pass_count increments and fail_count is unchanged.

Source files
------------

// File: rtl/cpu_test_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_test_sequencer
//
// Drives a CPU under test through a fixed table of {stimulus, expected}
// vectors. For each vector the CPU is held in reset with the stimulus on
// its input port, released, and then watched until its output port shows
// the expected value (pass) or a cycle budget runs out (fail).
//
// Parameters
//   NUM_TESTS   number of vector-table entries walked per pass
//   RST_CYCLES  cycles cpu_reset is held before each test
//   TIMEOUT     maximum RUN cycles allowed per test
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low block reset
//   start        begin a test pass (honoured only in IDLE or DONE)
//   cpu_out      CPU output port under observation
//   cpu_in       stimulus presented to the CPU input port
//   cpu_reset    active-high reset to the CPU
//   busy         high while in RESET, RUN or NEXT
//   done         high in DONE
//   test_idx     index of the current test
//   pass_count   tests whose output matched
//   fail_count   tests that timed out
//   cycle_total  cumulative RESET + RUN cycles (wraps modulo 2^32)
//   last_cycles  RUN cycles of the most recently finished test
// ---------------------------------------------------------------------------
module cpu_test_sequencer #(
    parameter int unsigned NUM_TESTS  = 3,
    parameter int unsigned RST_CYCLES = 2,
    parameter logic [15:0] TIMEOUT    = 16'd4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] cpu_out,
    output logic [15:0] cpu_in,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic [3:0]  test_idx,
    output logic [3:0]  pass_count,
    output logic [3:0]  fail_count,
    output logic [31:0] cycle_total,
    output logic [15:0] last_cycles
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_NEXT,
        ST_DONE
    } state_t;

    localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
    localparam logic [3:0]  IDX_LAST = 4'(NUM_TESTS - 1);

    // Vector table: stimulus half.
    function automatic logic [15:0] stim_of(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'h13B0;
            4'd1:    return 16'h0906;
            4'd2:    return 16'h754E;
            default: return 16'h0000;
        endcase
    endfunction

    // Vector table: expected-response half.
    function automatic logic [15:0] exp_of(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'h000B;
            4'd1:    return 16'd13;
            4'd2:    return 16'd17;
            default: return 16'h0000;
        endcase
    endfunction

    state_t      state, state_n;
    logic [15:0] rst_cnt, rst_cnt_n;   // cycles spent in the current RESET
    logic [15:0] run_cnt, run_cnt_n;   // 1-based RUN cycle of the current test
    logic [3:0]  test_idx_n, pass_n, fail_n;
    logic [31:0] total_n;
    logic [15:0] last_n, cpu_in_n;

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_n    = state;
        rst_cnt_n  = rst_cnt;
        run_cnt_n  = run_cnt;
        test_idx_n = test_idx;
        pass_n     = pass_count;
        fail_n     = fail_count;
        total_n    = cycle_total;
        last_n     = last_cycles;
        cpu_in_n   = cpu_in;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n    = ST_RESET;
                    rst_cnt_n  = 16'd0;
                    test_idx_n = 4'd0;
                    pass_n     = 4'd0;
                    fail_n     = 4'd0;
                    total_n    = 32'd0;
                    last_n     = 16'd0;
                    cpu_in_n   = stim_of(4'd0);
                end
            end

            ST_RESET: begin
                total_n = cycle_total + 32'd1;
                if (rst_cnt == RST_LAST) begin
                    state_n   = ST_RUN;
                    run_cnt_n = 16'd1;
                end else begin
                    rst_cnt_n = rst_cnt + 16'd1;
                end
            end

            ST_RUN: begin
                total_n = cycle_total + 32'd1;
                // Match is tested first so a match on the final allowed
                // cycle still counts as a pass.
                if (cpu_out == exp_of(test_idx)) begin
                    pass_n  = pass_count + 4'd1;
                    last_n  = run_cnt;
                    state_n = ST_NEXT;
                end else if (run_cnt == TIMEOUT) begin
                    fail_n  = fail_count + 4'd1;
                    last_n  = TIMEOUT;
                    state_n = ST_NEXT;
                end else begin
                    run_cnt_n = run_cnt + 16'd1;
                end
            end

            ST_NEXT: begin
                if (test_idx == IDX_LAST) begin
                    state_n = ST_DONE;
                end else begin
                    state_n    = ST_RESET;
                    test_idx_n = test_idx + 4'd1;
                    rst_cnt_n  = 16'd0;
                    cpu_in_n   = stim_of(test_idx + 4'd1);
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            rst_cnt     <= 16'd0;
            run_cnt     <= 16'd0;
            test_idx    <= 4'd0;
            pass_count  <= 4'd0;
            fail_count  <= 4'd0;
            cycle_total <= 32'd0;
            last_cycles <= 16'd0;
            cpu_in      <= 16'd0;
            cpu_reset   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            rst_cnt     <= rst_cnt_n;
            run_cnt     <= run_cnt_n;
            test_idx    <= test_idx_n;
            pass_count  <= pass_n;
            fail_count  <= fail_n;
            cycle_total <= total_n;
            last_cycles <= last_n;
            cpu_in      <= cpu_in_n;
            // Status flags are registered from the next state so they line
            // up with the state they describe.
            cpu_reset   <= (state_n != ST_RUN);
            busy        <= (state_n == ST_RESET) || (state_n == ST_RUN) ||
                           (state_n == ST_NEXT);
            done        <= (state_n == ST_DONE);
        end
    end

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_test_sequencer
//
// Bench for cpu_test_sequencer. A small CPU model answers each test with
// the expected value K cycles into RUN (K=0 means never), and a reference
// model computes pass/fail counts and cycle totals from the per-test K
// values using plain arithmetic.
// ---------------------------------------------------------------------------
module tb_cpu_test_sequencer;

    localparam int NT = 3;
    localparam int RC = 2;
    localparam int TO = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] cpu_out;
    logic [15:0] cpu_in;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic [3:0]  test_idx;
    logic [3:0]  pass_count;
    logic [3:0]  fail_count;
    logic [31:0] cycle_total;
    logic [15:0] last_cycles;

    cpu_test_sequencer #(
        .NUM_TESTS  (NT),
        .RST_CYCLES (RC),
        .TIMEOUT    (16'(TO))
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cpu_out     (cpu_out),
        .cpu_in      (cpu_in),
        .cpu_reset   (cpu_reset),
        .busy        (busy),
        .done        (done),
        .test_idx    (test_idx),
        .pass_count  (pass_count),
        .fail_count  (fail_count),
        .cycle_total (cycle_total),
        .last_cycles (last_cycles)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    int k_tab [NT];     // RUN cycle at which the CPU shows the answer, 0 = never
    bit early;          // drive 16'h000B while the CPU is held in reset
    int run_num;        // RUN phases seen since the last start
    bit in_run;
    int rc;
    int cur;

    typedef struct packed {
        logic [3:0]  pass;
        logic [3:0]  fail;
        logic [15:0] last;
        logic [31:0] total;
    } res_t;

    function automatic logic [15:0] stim(input int i);
        case (i)
            0:       return 16'h13B0;
            1:       return 16'h0906;
            default: return 16'h754E;
        endcase
    endfunction

    function automatic logic [15:0] exp_val(input int i);
        case (i)
            0:       return 16'h000B;
            1:       return 16'd13;
            default: return 16'd17;
        endcase
    endfunction

    // Reference: a test passes iff its answer appears within TO RUN
    // cycles; each test costs RC reset cycles plus its RUN cycles.
    function automatic res_t model();
        res_t r;
        int   run;
        r = '0;
        for (int i = 0; i < NT; i++) begin
            if (k_tab[i] >= 1 && k_tab[i] <= TO) begin
                run    = k_tab[i];
                r.pass = r.pass + 4'd1;
            end else begin
                run    = TO;
                r.fail = r.fail + 4'd1;
            end
            r.total = r.total + 32'(RC + run);
            r.last  = 16'(run);
        end
        return r;
    endfunction

    // CPU model: counts RUN cycles from the falling cpu_reset and also
    // confirms the stimulus on cpu_in during RUN.
    initial begin
        in_run  = 1'b0;
        rc      = 0;
        cur     = 0;
        cpu_out = 16'h0000;
        forever begin
            @(negedge clk);
            if (cpu_reset === 1'b0) begin
                if (!in_run) begin
                    in_run = 1'b1;
                    rc     = 0;
                    cur    = (run_num < NT) ? run_num : NT - 1;
                    run_num++;
                end
                rc++;
                tests_run++;
                if (cpu_in !== stim(cur)) begin
                    tests_failed++;
                    $display("FAIL run_cpu_in test %0d cycle %0d: got %h want %h", cur, rc, cpu_in, stim(cur));
                end
                if (k_tab[cur] != 0 && rc >= k_tab[cur])
                    cpu_out = exp_val(cur);
                else
                    cpu_out = exp_val(cur) ^ 16'($urandom_range(1, 65535));
            end else begin
                in_run  = 1'b0;
                cpu_out = early ? 16'h000B : 16'($urandom);
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        run_num = 0;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s done_timeout: done=%b after %0d cycles, want 1", name, done, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; early = 1'b0; run_num = 0;
        for (int i = 0; i < NT; i++) k_tab[i] = 0;
        repeat (2) @(negedge clk);
        tests_run++; if (cpu_reset !== 1'b1) begin tests_failed++; $display("FAIL reset cpu_reset: got %b want 1", cpu_reset); end
        tests_run++; if (cpu_in !== 16'h0) begin tests_failed++; $display("FAIL reset cpu_in: got %h want 0", cpu_in); end
        tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL reset busy/done: got %b/%b want 0/0", busy, done); end
        tests_run++; if (test_idx !== 4'd0 || pass_count !== 4'd0 || fail_count !== 4'd0) begin tests_failed++; $display("FAIL reset idx/pass/fail: got %0d/%0d/%0d want 0/0/0", test_idx, pass_count, fail_count); end
        tests_run++; if (cycle_total !== 32'd0 || last_cycles !== 16'd0) begin tests_failed++; $display("FAIL reset totals: got %0d/%0d want 0/0", cycle_total, last_cycles); end
        reset = 1'b1;
        repeat (5) @(negedge clk);
        tests_run++; if (busy !== 1'b0 || done !== 1'b0 || cpu_reset !== 1'b1) begin tests_failed++; $display("FAIL idle_wait: busy/done/cpu_reset got %b/%b/%b want 0/0/1", busy, done, cpu_reset); end
    endtask

    task automatic test_nominal();
        res_t r;
        k_tab[0] = 5; k_tab[1] = 7; k_tab[2] = 9;
        do_start();
        tests_run++; if (busy !== 1'b1 || cpu_reset !== 1'b1 || cpu_in !== 16'h13B0 || test_idx !== 4'd0) begin tests_failed++; $display("FAIL nominal_entry: busy/cpu_reset/cpu_in/idx got %b/%b/%h/%0d want 1/1/13b0/0", busy, cpu_reset, cpu_in, test_idx); end
        wait_done("nominal");
        r = model();
        tests_run++; if (pass_count !== r.pass) begin tests_failed++; $display("FAIL nominal pass_count: got %0d want %0d", pass_count, r.pass); end
        tests_run++; if (fail_count !== r.fail) begin tests_failed++; $display("FAIL nominal fail_count: got %0d want %0d", fail_count, r.fail); end
        tests_run++; if (last_cycles !== r.last) begin tests_failed++; $display("FAIL nominal last_cycles: got %0d want %0d", last_cycles, r.last); end
        tests_run++; if (cycle_total !== r.total) begin tests_failed++; $display("FAIL nominal cycle_total: got %0d want %0d", cycle_total, r.total); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL nominal busy_in_done: got %b want 0", busy); end
    endtask

    task automatic test_timeout();
        res_t r;
        int   n = 0;
        k_tab[0] = 5; k_tab[1] = 0; k_tab[2] = 9;
        do_start();
        while (test_idx !== 4'd2 && n < 200) begin @(negedge clk); n++; end
        tests_run++; if (test_idx !== 4'd2) begin tests_failed++; $display("FAIL timeout reach_test2: idx got %0d want 2", test_idx); end
        tests_run++; if (last_cycles !== 16'(TO) || fail_count !== 4'd1 || pass_count !== 4'd1) begin tests_failed++; $display("FAIL timeout after_test1: last/fail/pass got %0d/%0d/%0d want %0d/1/1", last_cycles, fail_count, pass_count, TO); end
        wait_done("timeout");
        r = model();
        tests_run++; if (pass_count !== r.pass) begin tests_failed++; $display("FAIL timeout pass_count: got %0d want %0d", pass_count, r.pass); end
        tests_run++; if (fail_count !== r.fail) begin tests_failed++; $display("FAIL timeout fail_count: got %0d want %0d", fail_count, r.fail); end
        tests_run++; if (cycle_total !== r.total) begin tests_failed++; $display("FAIL timeout cycle_total: got %0d want %0d", cycle_total, r.total); end
    endtask

    task automatic test_early_match();
        res_t r;
        int   n = 0;
        early = 1'b1;
        k_tab[0] = 1; k_tab[1] = 4; k_tab[2] = 2;
        do_start();
        while (cpu_reset !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        tests_run++; if (cpu_reset !== 1'b0 || pass_count !== 4'd0) begin tests_failed++; $display("FAIL early no_pass_in_reset: cpu_reset/pass got %b/%0d want 0/0", cpu_reset, pass_count); end
        n = 0;
        while (test_idx !== 4'd1 && n < 50) begin @(negedge clk); n++; end
        tests_run++; if (last_cycles !== 16'd1 || pass_count !== 4'd1) begin tests_failed++; $display("FAIL early pass_at_1: last/pass got %0d/%0d want 1/1", last_cycles, pass_count); end
        wait_done("early");
        r = model();
        tests_run++; if (pass_count !== r.pass || fail_count !== r.fail) begin tests_failed++; $display("FAIL early counts: pass/fail got %0d/%0d want %0d/%0d", pass_count, fail_count, r.pass, r.fail); end
        tests_run++; if (cycle_total !== r.total) begin tests_failed++; $display("FAIL early cycle_total: got %0d want %0d", cycle_total, r.total); end
        early = 1'b0;
    endtask

    task automatic test_start_ignored();
        res_t r;
        int   n = 0;
        k_tab[0] = 6; k_tab[1] = 3; k_tab[2] = 8;
        do_start();
        while (cpu_reset !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++; if (cpu_reset !== 1'b0 || busy !== 1'b1 || test_idx !== 4'd0) begin tests_failed++; $display("FAIL start_in_run: cpu_reset/busy/idx got %b/%b/%0d want 0/1/0", cpu_reset, busy, test_idx); end
        wait_done("start_ignored");
        r = model();
        tests_run++; if (pass_count !== r.pass || fail_count !== r.fail || cycle_total !== r.total) begin tests_failed++; $display("FAIL start_ignored result: pass/fail/total got %0d/%0d/%0d want %0d/%0d/%0d", pass_count, fail_count, cycle_total, r.pass, r.fail, r.total); end
        do_start();
        tests_run++; if (done !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL restart flags: done/busy got %b/%b want 0/1", done, busy); end
        tests_run++; if (pass_count !== 4'd0 || fail_count !== 4'd0 || last_cycles !== 16'd0 || test_idx !== 4'd0) begin tests_failed++; $display("FAIL restart clear: pass/fail/last/idx got %0d/%0d/%0d/%0d want 0/0/0/0", pass_count, fail_count, last_cycles, test_idx); end
        tests_run++; if (cycle_total !== 32'd0 || cpu_in !== 16'h13B0) begin tests_failed++; $display("FAIL restart total/cpu_in: got %0d/%h want 0/13b0", cycle_total, cpu_in); end
        wait_done("restart");
        tests_run++; if (pass_count !== r.pass || cycle_total !== r.total) begin tests_failed++; $display("FAIL restart result: pass/total got %0d/%0d want %0d/%0d", pass_count, cycle_total, r.pass, r.total); end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        k_tab[0] = 5; k_tab[1] = 0; k_tab[2] = 5;
        do_start();
        while (!(test_idx === 4'd1 && cpu_reset === 1'b0) && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        tests_run++; if (cpu_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cpu_in !== 16'h0) begin tests_failed++; $display("FAIL mid_reset flags: cpu_reset/busy/done/cpu_in got %b/%b/%b/%h want 1/0/0/0", cpu_reset, busy, done, cpu_in); end
        tests_run++; if (test_idx !== 4'd0 || pass_count !== 4'd0 || fail_count !== 4'd0 || cycle_total !== 32'd0 || last_cycles !== 16'd0) begin tests_failed++; $display("FAIL mid_reset counters: idx/pass/fail/total/last got %0d/%0d/%0d/%0d/%0d want all 0", test_idx, pass_count, fail_count, cycle_total, last_cycles); end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        tests_run++; if (busy !== 1'b0 || cpu_reset !== 1'b1 || cycle_total !== 32'd0) begin tests_failed++; $display("FAIL mid_reset idle: busy/cpu_reset/total got %b/%b/%0d want 0/1/0", busy, cpu_reset, cycle_total); end
    endtask

    task automatic test_timeout_edge();
        res_t r;
        for (int i = 0; i < NT; i++) k_tab[i] = TO;
        do_start();
        wait_done("timeout_edge");
        r = model();
        tests_run++; if (pass_count !== r.pass || fail_count !== r.fail) begin tests_failed++; $display("FAIL timeout_edge counts: pass/fail got %0d/%0d want %0d/%0d", pass_count, fail_count, r.pass, r.fail); end
        tests_run++; if (last_cycles !== r.last || cycle_total !== r.total) begin tests_failed++; $display("FAIL timeout_edge cycles: last/total got %0d/%0d want %0d/%0d", last_cycles, cycle_total, r.last, r.total); end
    endtask

    task automatic test_random();
        res_t r;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < NT; i++) k_tab[i] = int'($urandom_range(0, TO + 2));
            early = 1'($urandom_range(0, 1));
            do_start();
            wait_done("random");
            r = model();
            tests_run++; if (pass_count !== r.pass || fail_count !== r.fail) begin tests_failed++; $display("FAIL random[%0d] counts: pass/fail got %0d/%0d want %0d/%0d", it, pass_count, fail_count, r.pass, r.fail); end
            tests_run++; if (last_cycles !== r.last || cycle_total !== r.total) begin tests_failed++; $display("FAIL random[%0d] cycles: last/total got %0d/%0d want %0d/%0d", it, last_cycles, cycle_total, r.last, r.total); end
        end
        early = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_early_match();
        test_start_ignored();
        test_mid_reset();
        test_timeout_edge();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
